// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-through capture, EX/MEM and MEM/WB operand
// forwarding, ALU operand selection and load-use hazard detection.
module id_ex_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [4:0]        id_alu_ctrl,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_dest,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_shamt,
    input  logic              id_a_shamt,
    input  logic              id_b_imm,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              id_branch,
    input  logic              flush,
    input  logic              exmem_reg_write,
    input  logic [4:0]        exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [4:0]        memwb_rd,
    input  logic [DATA_W-1:0] memwb_result,
    output logic [4:0]        ctrl,
    output logic [DATA_W-1:0] selected_A,
    output logic [DATA_W-1:0] selected_B,
    output logic [DATA_W-1:0] ex_store_data,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              ex_branch,
    output logic [4:0]        ex_dest,
    output logic              hazard_stall
);

    typedef struct packed {
        logic              valid;
        logic [4:0]        alu_ctrl;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        dest;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [4:0]        shamt;
        logic              a_shamt;
        logic              b_imm;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic              branch;
    } ex_reg_t;

    ex_reg_t           ex_q;
    ex_reg_t           ex_d;
    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

    // Register 0 is hard-wired, so a write to it is never a forwarding source.
    function automatic logic src_hit(input logic we, input logic [4:0] rd, input logic [4:0] idx);
        return we && (rd != 5'd0) && (rd == idx);
    endfunction

    assign hazard_stall = id_valid && ex_q.valid && ex_q.mem_read && (ex_q.dest != 5'd0)
                          && ((ex_q.dest == id_rs) || (ex_q.dest == id_rt));

    always_comb begin
        ex_d = '0;
        if (!(flush || hazard_stall)) begin
            ex_d.valid      = id_valid;
            ex_d.alu_ctrl   = id_alu_ctrl;
            ex_d.rs         = id_rs;
            ex_d.rt         = id_rt;
            ex_d.dest       = id_dest;
            // The register file read is stale when WB writes the same register this cycle.
            ex_d.rs_data    = src_hit(memwb_reg_write, memwb_rd, id_rs) ? memwb_result : id_rs_data;
            ex_d.rt_data    = src_hit(memwb_reg_write, memwb_rd, id_rt) ? memwb_result : id_rt_data;
            ex_d.imm        = id_imm;
            ex_d.shamt      = id_shamt;
            ex_d.a_shamt    = id_a_shamt;
            ex_d.b_imm      = id_b_imm;
            ex_d.reg_write  = id_reg_write;
            ex_d.mem_read   = id_mem_read;
            ex_d.mem_write  = id_mem_write;
            ex_d.mem_to_reg = id_mem_to_reg;
            ex_d.branch     = id_branch;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    always_comb begin
        fwd_rs = ex_q.rs_data;
        if (src_hit(exmem_reg_write, exmem_rd, ex_q.rs)) begin
            fwd_rs = exmem_result;
        end else if (src_hit(memwb_reg_write, memwb_rd, ex_q.rs)) begin
            fwd_rs = memwb_result;
        end
        fwd_rt = ex_q.rt_data;
        if (src_hit(exmem_reg_write, exmem_rd, ex_q.rt)) begin
            fwd_rt = exmem_result;
        end else if (src_hit(memwb_reg_write, memwb_rd, ex_q.rt)) begin
            fwd_rt = memwb_result;
        end
    end

    assign ctrl          = ex_q.alu_ctrl;
    assign selected_A    = ex_q.a_shamt ? {{(DATA_W-5){1'b0}}, ex_q.shamt} : fwd_rs;
    assign selected_B    = ex_q.b_imm ? ex_q.imm : fwd_rt;
    assign ex_store_data = fwd_rt;
    assign ex_valid      = ex_q.valid;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_mem_to_reg = ex_q.mem_to_reg;
    assign ex_branch     = ex_q.branch;
    assign ex_dest       = ex_q.dest;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic checked
// against an instruction-level model of the stage.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_alu_ctrl, id_rs, id_rt, id_dest, id_shamt;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic        id_a_shamt, id_b_imm, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch;
    logic        flush;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic [4:0]  ctrl, ex_dest;
    logic [31:0] selected_A, selected_B, ex_store_data;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch;
    logic        hazard_stall;

    id_ex_stage #(.DATA_W(32)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_alu_ctrl(id_alu_ctrl),
        .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest), .id_rs_data(id_rs_data),
        .id_rt_data(id_rt_data), .id_imm(id_imm), .id_shamt(id_shamt),
        .id_a_shamt(id_a_shamt), .id_b_imm(id_b_imm), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .id_branch(id_branch), .flush(flush), .exmem_reg_write(exmem_reg_write),
        .exmem_rd(exmem_rd), .exmem_result(exmem_result), .memwb_reg_write(memwb_reg_write),
        .memwb_rd(memwb_rd), .memwb_result(memwb_result), .ctrl(ctrl),
        .selected_A(selected_A), .selected_B(selected_B), .ex_store_data(ex_store_data),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch),
        .ex_dest(ex_dest), .hazard_stall(hazard_stall)
    );

    always #5 clk = ~clk;

    // The instruction currently sitting in EX, as the model sees it.
    typedef struct {
        bit        valid;
        bit [4:0]  op, rs, rt, dest, shamt;
        bit [31:0] a, b, imm;
        bit        use_shamt, use_imm, rw, mr, mw, m2r, br;
    } instr_t;

    instr_t m;
    int errors = 0;
    int checks = 0;
    int txn    = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Value of register idx as seen in EX: newest in-flight writer first, else the latched value.
    function automatic bit [31:0] operand(input bit [4:0] idx, input bit [31:0] latched);
        bit        we [2];
        bit [4:0]  rd [2];
        bit [31:0] val [2];
        we  = '{exmem_reg_write, memwb_reg_write};
        rd  = '{exmem_rd, memwb_rd};
        val = '{exmem_result, memwb_result};
        for (int k = 0; k < 2; k++) begin
            if (idx != 0 && we[k] && rd[k] == idx) return val[k];
        end
        return latched;
    endfunction

    function automatic bit [31:0] reg_read(input bit [4:0] idx, input bit [31:0] rf_value);
        if (idx != 0 && memwb_reg_write && memwb_rd == idx) return memwb_result;
        return rf_value;
    endfunction

    function automatic bit model_stall();
        return id_valid && m.valid && m.mr && m.dest != 0 && (m.dest == id_rs || m.dest == id_rt);
    endfunction

    task automatic compare_all();
        #1;
        check_eq("hazard_stall", hazard_stall, model_stall());
        check_eq("ctrl", ctrl, m.op);
        check_eq("selected_A", selected_A, m.use_shamt ? {27'b0, m.shamt} : operand(m.rs, m.a));
        check_eq("selected_B", selected_B, m.use_imm ? m.imm : operand(m.rt, m.b));
        check_eq("ex_store_data", ex_store_data, operand(m.rt, m.b));
        check_eq("ex_ctrl_bits", {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch},
                 {m.valid, m.rw, m.mr, m.mw, m.m2r, m.br});
        check_eq("ex_dest", ex_dest, m.dest);
    endtask

    task automatic capture_model();
        if (flush || model_stall()) begin
            m = '{default: 0};
        end else begin
            m.valid = id_valid;  m.op = id_alu_ctrl;  m.rs = id_rs;  m.rt = id_rt;  m.dest = id_dest;
            m.a = reg_read(id_rs, id_rs_data);  m.b = reg_read(id_rt, id_rt_data);
            m.imm = id_imm;  m.shamt = id_shamt;  m.use_shamt = id_a_shamt;  m.use_imm = id_b_imm;
            m.rw = id_reg_write;  m.mr = id_mem_read;  m.mw = id_mem_write;
            m.m2r = id_mem_to_reg;  m.br = id_branch;
        end
    endtask

    // Called just after a falling edge with inputs set up; returns after the next falling edge.
    task automatic tick();
        compare_all();
        @(posedge clk);
        capture_model();
        txn++;
        $display("txn %0d: valid=%0b op=%0d dest=%0d A=%08h B=%08h store=%08h",
                 txn, m.valid, m.op, m.dest, selected_A, selected_B, ex_store_data);
        @(negedge clk);
    endtask

    task automatic set_idle();
        id_valid = 0;  id_alu_ctrl = 0;  id_rs = 0;  id_rt = 0;  id_dest = 0;  id_shamt = 0;
        id_rs_data = 0;  id_rt_data = 0;  id_imm = 0;  id_a_shamt = 0;  id_b_imm = 0;
        id_reg_write = 0;  id_mem_read = 0;  id_mem_write = 0;  id_mem_to_reg = 0;  id_branch = 0;
        flush = 0;  exmem_reg_write = 0;  exmem_rd = 0;  exmem_result = 0;
        memwb_reg_write = 0;  memwb_rd = 0;  memwb_result = 0;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_ctrl"}, ctrl, 0);
        check_eq({tag, "_A"}, selected_A, 0);
        check_eq({tag, "_B"}, selected_B, 0);
        check_eq({tag, "_store"}, ex_store_data, 0);
        check_eq({tag, "_bits"}, {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, ex_dest}, 0);
        check_eq({tag, "_stall"}, hazard_stall, 0);
    endtask

    initial begin
        set_idle();
        m = '{default: 0};
        reset = 1;
        @(negedge clk);
        @(negedge clk);
        check_reset_state("reset");
        reset = 0;

        // add: 5 + 7
        id_valid = 1;  id_rs = 1;  id_rt = 2;  id_rs_data = 5;  id_rt_data = 7;
        id_reg_write = 1;  id_dest = 3;
        tick();
        check_eq("add_A", selected_A, 5);
        check_eq("add_B", selected_B, 7);
        check_eq("add_valid", ex_valid, 1);
        check_eq("add_rw", ex_reg_write, 1);

        // forwarding priority on rs=3
        set_idle();
        id_valid = 1;  id_rs = 3;  id_rs_data = 32'h11;
        tick();
        exmem_reg_write = 1;  exmem_rd = 3;  exmem_result = 32'hAAAA;
        memwb_reg_write = 1;  memwb_rd = 3;  memwb_result = 32'hBBBB;
        #1 check_eq("prio_exmem", selected_A, 32'hAAAA);
        exmem_reg_write = 0;
        #1 check_eq("prio_memwb", selected_A, 32'hBBBB);
        set_idle();
        id_valid = 1;  id_rs = 0;  id_rs_data = 32'h22;
        tick();
        exmem_reg_write = 1;  exmem_rd = 0;  exmem_result = 32'hAAAA;
        memwb_reg_write = 1;  memwb_rd = 0;  memwb_result = 32'hBBBB;
        #1 check_eq("prio_r0", selected_A, 32'h22);

        // load-use on $4
        set_idle();
        id_valid = 1;  id_mem_read = 1;  id_reg_write = 1;  id_mem_to_reg = 1;  id_dest = 4;
        tick();
        set_idle();
        id_valid = 1;  id_rs = 4;  id_rt = 5;  id_reg_write = 1;  id_dest = 7;
        #1 check_eq("lu_stall", hazard_stall, 1);
        tick();
        check_eq("lu_bubble", ex_valid, 0);
        tick();
        memwb_reg_write = 1;  memwb_rd = 4;  memwb_result = 32'h1234;
        #1 check_eq("lu_fwd", selected_A, 32'h1234);

        // flush squashes a valid instruction
        set_idle();
        id_valid = 1;  id_reg_write = 1;  id_alu_ctrl = 3;  id_dest = 9;  flush = 1;
        tick();
        check_eq("flush_valid", ex_valid, 0);
        check_eq("flush_rw", ex_reg_write, 0);
        check_eq("flush_ctrl", ctrl, 0);

        // shift amount and immediate selection
        set_idle();
        id_valid = 1;  id_alu_ctrl = 7;  id_a_shamt = 1;  id_shamt = 4;  id_rt = 2;  id_rt_data = 1;
        tick();
        check_eq("sll_A", selected_A, 4);
        check_eq("sll_B", selected_B, 1);
        id_a_shamt = 0;  id_b_imm = 1;  id_imm = 32'hFFFF_FFF0;  id_rt_data = 32'h99;
        tick();
        check_eq("imm_B", selected_B, 32'hFFFF_FFF0);
        check_eq("imm_store", ex_store_data, 32'h99);

        // write-through of a same-cycle WB write
        set_idle();
        id_valid = 1;  id_rs = 6;  id_rs_data = 0;
        memwb_reg_write = 1;  memwb_rd = 6;  memwb_result = 32'h55;
        tick();
        memwb_reg_write = 0;
        #1 check_eq("wt_A", selected_A, 32'h55);

        // randomized traffic with occasional asynchronous reset
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(49) == 0) begin
                reset = 1;
                #1 check_reset_state("async_reset");
                m = '{default: 0};
                #1 reset = 0;
            end
            id_valid = 1'($urandom_range(3) != 0);
            id_alu_ctrl = 5'($urandom_range(9));
            id_rs = 5'($urandom_range(7));  id_rt = 5'($urandom_range(7));  id_dest = 5'($urandom_range(7));
            id_rs_data = $urandom;  id_rt_data = $urandom;  id_imm = $urandom;  id_shamt = 5'($urandom);
            id_a_shamt = 1'($urandom_range(3) == 0);  id_b_imm = 1'($urandom);
            id_reg_write = 1'($urandom);  id_mem_read = 1'($urandom_range(2) == 0);
            id_mem_write = 1'($urandom);  id_mem_to_reg = 1'($urandom);  id_branch = 1'($urandom);
            flush = 1'($urandom_range(7) == 0);
            exmem_reg_write = 1'($urandom);  exmem_rd = 5'($urandom_range(7));  exmem_result = $urandom;
            memwb_reg_write = 1'($urandom);  memwb_rd = 5'($urandom_range(7));  memwb_result = $urandom;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
